npu_seq: RTL and testbench
==========================

# npu_seq

Element-loop sequencer directly downstream of the CPU register interface. On START it snapshots the region registers and walks the input-A and input-B memories one element per cycle. It times the output-C write strobes to the datapath latency and tracks the max/min of written results. It returns a one-cycle FINISH pulse, which the register block turns into INT and its run flag.

## Interface
- LAT, 3: datapath latency, RD_EN to RES_DATA valid, in cycles; legal 1..15.
- ADDR_W, 10: memory address width.
- DATA_W, 8: result width; unsigned.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SOFT_RESET  in  1  synchronous one-cycle clear pulse.
- START  in  1  one-cycle start pulse.
- OP  in  2  0:ADD 1:MUL 2:RQT 3:illegal.
- M1POS, M1SIZE  in  ADDR_W each  input-A base address and element count (count for whole op).
- M2POS  in  ADDR_W  input-B base address.
- M3POS  in  ADDR_W  output-C base address.
- RD_EN  out  1  read strobe to A/B memories.
- RD_ADDR_A, RD_ADDR_B  out  ADDR_W each  read addresses.
- RES_DATA  in  DATA_W  datapath result, valid LAT cycles after its RD_EN.
- WR_EN  out  1  write strobe to C memory.
- WR_ADDR  out  ADDR_W  write address.
- WR_DATA  out  DATA_W  RES_DATA passed through combinationally.
- BUSY  out  1  sequencer not IDLE.
- FINISH  out  1  one-cycle completion pulse.
- RMAX, RMIN  out  DATA_W each  running max/min of written results.

## Operation
- States:
  - IDLE: wait for START.
  - RUN: issue reads.
  - DRAIN: wait for the last LAT writes.
  - DONE: FINISH=1 for one cycle, then IDLE.
- START in IDLE:
  - Snapshot OP, M1SIZE (N) and all POS values into internal registers; later register writes do not affect the running op.
  - RMAX←0x00, RMIN←0xFF.
- Transitions out of IDLE on START:
  - OP=3 → DONE directly; no RD_EN/WR_EN issued.
  - N=0 → DONE directly; no RD_EN/WR_EN issued.
  - Otherwise → RUN.
- RUN, element k = 0..N-1, one per cycle:
  - RD_EN=1, RD_ADDR_A=A_POS+k, RD_ADDR_B=B_POS+k.
  - After k=N-1, go to DRAIN.
- Write strobe:
  - WR_EN is RD_EN delayed exactly LAT cycles.
  - WR_ADDR=C_POS+j, with j the write count since START.
- DRAIN → DONE in the cycle after the last WR_EN.
- All address sums are mod 2^ADDR_W (wrap at 1023→0, no error).
- Each WR_EN cycle: RMAX←max(RMAX,RES_DATA), RMIN←min(RMIN,RES_DATA), unsigned compare.
- START while BUSY: ignored.
- SOFT_RESET, any state, highest priority:
  - Next cycle IDLE; delay line cleared; counters cleared; RMAX/RMIN to reset values.
  - No FINISH generated.
  - A simultaneous START is ignored.
- Reset values (RESET or SOFT_RESET): RD_EN=0, WR_EN=0, RD_ADDR_*=0, WR_ADDR=0, BUSY=0, FINISH=0, RMAX=0x00, RMIN=0xFF, state IDLE.

## Timing
- START high in cycle t; N≥1, OP≠3:
  - RD_EN high t+1..t+N.
  - WR_EN high t+1+LAT..t+N+LAT.
  - FINISH high t+N+LAT+1.
  - BUSY high t+1..t+N+LAT+1 inclusive.
- N=0 or OP=3: FINISH at t+1, BUSY at t+1 only.
- RMAX/RMIN registered on WR_EN cycles. Final values are valid in the FINISH cycle and held until the next START or reset.
- All outputs are registered, except WR_DATA (passthrough).
- Back-to-back: a START in the FINISH cycle is ignored. Earliest accepted restart is t+N+LAT+2.

## Structure
- Shared package npu_pkg:
  - seq_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - OP code constants OP_ADD/OP_MUL/OP_RQT.
  - NPU_ADDR_W=10, NPU_DATA_W=8.
- Sub-module npu_vld_delay: LAT-deep shift register of the valid bit with synchronous clear. It generates WR_EN and is reusable by the datapath stages.
- Remainder in npu_seq: FSM, read/write counters, POS snapshot, max/min tracker.

## Test plan
- LAT=3, M1SIZE=4, M1POS=0x010, M2POS=0x100, M3POS=0x200, START at t → RD_ADDR_A 0x010..0x013 at t+1..t+4; WR_ADDR 0x200..0x203 at t+4..t+7; FINISH at t+8.
- RES_DATA sequence 0x40,0x05,0xF0,0x80 on WR_EN cycles → RMAX=0xF0, RMIN=0x05 in the FINISH cycle.
- M1SIZE=0, then separately OP=3 → FINISH at t+1; zero RD_EN/WR_EN pulses; RMAX=0x00, RMIN=0xFF.
- M1POS=0x3FE, M3POS=0x3FF, M1SIZE=3 → RD_ADDR_A 0x3FE,0x3FF,0x000; WR_ADDR 0x3FF,0x000,0x001.
- SOFT_RESET at t+2 of a 10-element run → IDLE at t+3; no further RD_EN/WR_EN; no FINISH; RMIN=0xFF. A new START then runs normally.
- START re-pulsed at t+2 mid-run, and M1POS rewritten to 0x050 during run → ignored; addresses continue from the snapshot; exactly N writes; one FINISH. Asserting RESET mid-run forces all reset values asynchronously.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU control path.
package npu_pkg;
   localparam int NPU_ADDR_W = 10;
   localparam int NPU_DATA_W = 8;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_MUL = 2'd1;
   localparam logic [1:0] OP_RQT = 2'd2;
   localparam logic [1:0] OP_ILL = 2'd3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/npu_vld_delay.sv
// Fixed-latency shift register for a valid bit; synchronous clear flushes
// every stage so no stale strobe emerges after an abort.
module npu_vld_delay #(
   parameter int LAT = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic vld_i,
   output logic vld_o
);
   logic [LAT-1:0] sr_q;
   logic [LAT-1:0] sr_d;

   always_comb begin
      sr_d = '0;
      if (!clr_i) begin
         sr_d[0] = vld_i;
         for (int i = 1; i < LAT; i++) begin
            sr_d[i] = sr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign vld_o = sr_q[LAT-1];
endmodule

// File: rtl/npu_seq.sv
// Element-loop sequencer: issues one A/B read per cycle, times C writes to the
// datapath latency, tracks max/min of written results and pulses FINISH.
module npu_seq
   import npu_pkg::*;
#(
   parameter int LAT    = 3,
   parameter int ADDR_W = NPU_ADDR_W,
   parameter int DATA_W = NPU_DATA_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SOFT_RESET,
   input  logic              START,
   input  logic [1:0]        OP,
   input  logic [ADDR_W-1:0] M1POS,
   input  logic [ADDR_W-1:0] M1SIZE,
   input  logic [ADDR_W-1:0] M2POS,
   input  logic [ADDR_W-1:0] M3POS,
   output logic              RD_EN,
   output logic [ADDR_W-1:0] RD_ADDR_A,
   output logic [ADDR_W-1:0] RD_ADDR_B,
   input  logic [DATA_W-1:0] RES_DATA,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [DATA_W-1:0] WR_DATA,
   output logic              BUSY,
   output logic              FINISH,
   output logic [DATA_W-1:0] RMAX,
   output logic [DATA_W-1:0] RMIN
);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   seq_state_t        state_q, state_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
   logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [DATA_W-1:0] rmax_q, rmax_d;
   logic [DATA_W-1:0] rmin_q, rmin_d;
   logic              busy_q, busy_d;
   logic              finish_q, finish_d;
   logic              wr_en;

   npu_vld_delay #(.LAT(LAT)) u_wr_dly (
      .clk_i (CLK),
      .rst_i (RESET),
      .clr_i (SOFT_RESET),
      .vld_i (rd_en_q),
      .vld_o (wr_en)
   );

   always_comb begin
      state_d     = state_q;
      rd_en_d     = 1'b0;
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      wr_addr_d   = wr_addr_q;
      n_d         = n_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      rmax_d      = rmax_q;
      rmin_d      = rmin_q;

      if (wr_en) begin
         wr_addr_d = wr_addr_q + ONE;
         wr_cnt_d  = wr_cnt_q + ONE;
         if (RES_DATA > rmax_q) rmax_d = RES_DATA;
         if (RES_DATA < rmin_q) rmin_d = RES_DATA;
      end

      unique case (state_q)
         IDLE: begin
            if (START) begin
               // Address counters are loaded here, so they act as the snapshot.
               n_d       = M1SIZE;
               wr_addr_d = M3POS;
               wr_cnt_d  = '0;
               rmax_d    = '0;
               rmin_d    = '1;
               if (OP == OP_ILL || M1SIZE == '0) begin
                  state_d = DONE;
               end else begin
                  state_d     = RUN;
                  rd_en_d     = 1'b1;
                  rd_addr_a_d = M1POS;
                  rd_addr_b_d = M2POS;
                  rd_cnt_d    = ONE;
               end
            end
         end
         RUN: begin
            if (rd_cnt_q == n_q) begin
               state_d = DRAIN;
            end else begin
               rd_en_d     = 1'b1;
               rd_addr_a_d = rd_addr_a_q + ONE;
               rd_addr_b_d = rd_addr_b_q + ONE;
               rd_cnt_d    = rd_cnt_q + ONE;
            end
         end
         DRAIN: begin
            if (wr_en && (wr_cnt_q + ONE) == n_q) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (SOFT_RESET) begin
         state_d     = IDLE;
         rd_en_d     = 1'b0;
         rd_addr_a_d = '0;
         rd_addr_b_d = '0;
         wr_addr_d   = '0;
         n_d         = '0;
         rd_cnt_d    = '0;
         wr_cnt_d    = '0;
         rmax_d      = '0;
         rmin_d      = '1;
      end

      busy_d   = (state_d != IDLE);
      finish_d = (state_d == DONE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         rd_en_q     <= 1'b0;
         rd_addr_a_q <= '0;
         rd_addr_b_q <= '0;
         wr_addr_q   <= '0;
         n_q         <= '0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         rmax_q      <= '0;
         rmin_q      <= '1;
         busy_q      <= 1'b0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_en_q     <= rd_en_d;
         rd_addr_a_q <= rd_addr_a_d;
         rd_addr_b_q <= rd_addr_b_d;
         wr_addr_q   <= wr_addr_d;
         n_q         <= n_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         rmax_q      <= rmax_d;
         rmin_q      <= rmin_d;
         busy_q      <= busy_d;
         finish_q    <= finish_d;
      end
   end

   assign RD_EN     = rd_en_q;
   assign RD_ADDR_A = rd_addr_a_q;
   assign RD_ADDR_B = rd_addr_b_q;
   assign WR_EN     = wr_en;
   assign WR_ADDR   = wr_addr_q;
   assign WR_DATA   = RES_DATA;
   assign BUSY      = busy_q;
   assign FINISH    = finish_q;
   assign RMAX      = rmax_q;
   assign RMIN      = rmin_q;
endmodule

// File: tb/tb_npu_seq.sv
// Bench for npu_seq: directed scenarios plus random traffic, every cycle
// compared against a run-window model of the sequencer.
module tb_npu_seq;
   localparam int LAT = 3;

   logic       CLK;
   logic       RESET;
   logic       SOFT_RESET;
   logic       START;
   logic [1:0] OP;
   logic [9:0] M1POS, M1SIZE, M2POS, M3POS;
   logic       RD_EN;
   logic [9:0] RD_ADDR_A, RD_ADDR_B;
   logic [7:0] RES_DATA;
   logic       WR_EN;
   logic [9:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic       BUSY, FINISH;
   logic [7:0] RMAX, RMIN;

   npu_seq #(.LAT(LAT), .ADDR_W(10), .DATA_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .SOFT_RESET(SOFT_RESET), .START(START), .OP(OP),
      .M1POS(M1POS), .M1SIZE(M1SIZE), .M2POS(M2POS), .M3POS(M3POS),
      .RD_EN(RD_EN), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
      .RES_DATA(RES_DATA), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .BUSY(BUSY), .FINISH(FINISH), .RMAX(RMAX), .RMIN(RMIN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: the accepted run is described by its start cycle and
   // length; expected strobes follow from the timing windows.
   bit         alive = 1'b0;
   bit         short_s = 1'b0;
   bit         zero_chk = 1'b0;
   int         t_s = 0, n_s = 0, end_s = 0;
   logic [9:0] ap = '0, bp = '0, cp = '0;
   logic [7:0] m_max = 8'h00, m_min = 8'hFF;
   int         wr_seen = 0, fin_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [9:0] wrap(input logic [9:0] base, input int off);
      logic [9:0] o;
      o = 10'(off);
      return base + o;
   endfunction

   task automatic tick();
      bit e_busy, e_fin, e_rd, e_wr;
      @(negedge CLK);
      e_busy = alive && cyc >= t_s + 1 && cyc <= end_s;
      e_fin  = alive && cyc == end_s;
      e_rd   = alive && !short_s && cyc >= t_s + 1 && cyc <= t_s + n_s;
      e_wr   = alive && !short_s && cyc >= t_s + 1 + LAT && cyc <= t_s + n_s + LAT;
      chk("busy", 32'(BUSY), 32'(e_busy));
      chk("finish", 32'(FINISH), 32'(e_fin));
      chk("rd_en", 32'(RD_EN), 32'(e_rd));
      chk("wr_en", 32'(WR_EN), 32'(e_wr));
      chk("rmax", 32'(RMAX), 32'(m_max));
      chk("rmin", 32'(RMIN), 32'(m_min));
      chk("wr_data", 32'(WR_DATA), 32'(RES_DATA));
      if (e_rd) begin
         chk("rd_addr_a", 32'(RD_ADDR_A), 32'(wrap(ap, cyc - t_s - 1)));
         chk("rd_addr_b", 32'(RD_ADDR_B), 32'(wrap(bp, cyc - t_s - 1)));
      end
      if (e_wr) chk("wr_addr", 32'(WR_ADDR), 32'(wrap(cp, cyc - t_s - 1 - LAT)));
      if (zero_chk) begin
         chk("rst_rd_addr_a", 32'(RD_ADDR_A), 32'(0));
         chk("rst_rd_addr_b", 32'(RD_ADDR_B), 32'(0));
         chk("rst_wr_addr", 32'(WR_ADDR), 32'(0));
         zero_chk = 1'b0;
      end
      if (WR_EN) wr_seen++;
      if (FINISH) fin_seen++;

      if (e_wr) begin
         if (RES_DATA > m_max) m_max = RES_DATA;
         if (RES_DATA < m_min) m_min = RES_DATA;
      end
      if (SOFT_RESET) begin
         alive = 1'b0; m_max = 8'h00; m_min = 8'hFF; zero_chk = 1'b1;
      end else if (START && !e_busy) begin
         alive = 1'b1; t_s = cyc; n_s = int'(M1SIZE);
         short_s = (OP == 2'd3) || (M1SIZE == 10'd0);
         end_s = short_s ? cyc + 1 : cyc + n_s + LAT + 1;
         ap = M1POS; bp = M2POS; cp = M3POS;
         m_max = 8'h00; m_min = 8'hFF;
      end

      @(posedge CLK);
      #1;
      cyc++;
      START = 1'b0;
      SOFT_RESET = 1'b0;
      RES_DATA = 8'($urandom);
      M1POS = 10'($urandom);
      M2POS = 10'($urandom);
      M3POS = 10'($urandom);
      M1SIZE = 10'($urandom_range(0, 12));
      OP = 2'($urandom);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_start(input logic [1:0] op, input int n,
                            input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
      OP = op; M1SIZE = 10'(n); M1POS = a; M2POS = b; M3POS = c; START = 1'b1;
      tick();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rd_en"}, 32'(RD_EN), 32'(0));
      chk({tag, "_wr_en"}, 32'(WR_EN), 32'(0));
      chk({tag, "_rd_addr_a"}, 32'(RD_ADDR_A), 32'(0));
      chk({tag, "_rd_addr_b"}, 32'(RD_ADDR_B), 32'(0));
      chk({tag, "_wr_addr"}, 32'(WR_ADDR), 32'(0));
      chk({tag, "_busy"}, 32'(BUSY), 32'(0));
      chk({tag, "_finish"}, 32'(FINISH), 32'(0));
      chk({tag, "_rmax"}, 32'(RMAX), 32'h00);
      chk({tag, "_rmin"}, 32'(RMIN), 32'hFF);
   endtask

   logic [7:0] seq [4];

   initial begin
      RESET = 1'b1; SOFT_RESET = 1'b0; START = 1'b0; OP = 2'd0;
      M1POS = '0; M1SIZE = '0; M2POS = '0; M3POS = '0; RES_DATA = '0;
      repeat (2) @(posedge CLK);
      #1;
      check_reset_values("por");
      RESET = 1'b0;

      // Basic 4-element run with directed result data.
      seq[0] = 8'h40; seq[1] = 8'h05; seq[2] = 8'hF0; seq[3] = 8'h80;
      ticks(2);
      run_start(2'd0, 4, 10'h010, 10'h100, 10'h200);
      for (int i = 1; i <= 9; i++) begin
         if (i >= 4 && i <= 7) RES_DATA = seq[i-4];
         tick();
      end
      chk("tp1_rmax", 32'(RMAX), 32'hF0);
      chk("tp1_rmin", 32'(RMIN), 32'h05);

      // Zero-length op and illegal opcode finish immediately.
      wr_seen = 0; fin_seen = 0;
      run_start(2'd1, 0, 10'h020, 10'h030, 10'h040);
      ticks(3);
      chk("n0_rmax", 32'(RMAX), 32'h00);
      chk("n0_rmin", 32'(RMIN), 32'hFF);
      run_start(2'd3, 5, 10'h020, 10'h030, 10'h040);
      ticks(4);
      chk("op3_wr_count", 32'(wr_seen), 32'(0));
      chk("op3_fin_count", 32'(fin_seen), 32'(2));

      // Address wrap at the top of memory.
      run_start(2'd1, 3, 10'h3FE, 10'h3FD, 10'h3FF);
      ticks(9);

      // Soft reset mid-run, then a normal run.
      wr_seen = 0; fin_seen = 0;
      run_start(2'd0, 10, 10'h100, 10'h180, 10'h300);
      tick();
      SOFT_RESET = 1'b1;
      tick();
      ticks(16);
      chk("srst_rmin", 32'(RMIN), 32'hFF);
      chk("srst_fin_count", 32'(fin_seen), 32'(0));
      run_start(2'd2, 5, 10'h011, 10'h022, 10'h033);
      ticks(10);

      // Re-pulsed START and rewritten M1POS mid-run are ignored.
      wr_seen = 0; fin_seen = 0;
      run_start(2'd0, 6, 10'h080, 10'h090, 10'h0A0);
      tick();
      START = 1'b1; M1POS = 10'h050;
      tick();
      ticks(11);
      chk("rep_wr_count", 32'(wr_seen), 32'(6));
      chk("rep_fin_count", 32'(fin_seen), 32'(1));

      // START in the FINISH cycle is ignored; one cycle later it is taken.
      run_start(2'd1, 2, 10'h001, 10'h002, 10'h003);
      ticks(LAT + 2);
      START = 1'b1; M1SIZE = 10'd2;
      tick();
      START = 1'b1; OP = 2'd0; M1SIZE = 10'd2;
      tick();
      ticks(LAT + 4);

      // Asynchronous reset mid-run.
      run_start(2'd0, 8, 10'h200, 10'h210, 10'h220);
      ticks(5);
      RESET = 1'b1;
      #1;
      check_reset_values("arst");
      #1;
      RESET = 1'b0;
      alive = 1'b0; m_max = 8'h00; m_min = 8'hFF; zero_chk = 1'b1;
      ticks(12);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         START = ($urandom_range(0, 3) == 0);
         SOFT_RESET = ($urandom_range(0, 39) == 0);
         M1SIZE = 10'($urandom_range(0, 8));
         tick();
      end
      ticks(LAT + 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
